// File: rtl/pll_reconfig_pkg.sv
// Shared types, reconfig-core register map and the output-profile table for pll_reconfig_seq.
// All profiles share one VCO setting; only the C0 divider differs between them.
package pll_reconfig_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StWrMode,
      StWrM,
      StWrN,
      StWrK,
      StWrC0,
      StWrStart,
      StPoll,
      StWaitLock,
      StDone,
      StErr
   } state_e;

   localparam logic [5:0] AddrMode   = 6'd0;
   localparam logic [5:0] AddrStatus = 6'd1;
   localparam logic [5:0] AddrStart  = 6'd2;
   localparam logic [5:0] AddrN      = 6'd3;
   localparam logic [5:0] AddrM      = 6'd4;
   localparam logic [5:0] AddrC0     = 6'd5;
   localparam logic [5:0] AddrK      = 6'd7;

   // Counter word: [22:18] counter select, [17] odd duty, [16] bypass, [15:8] hi, [7:0] lo.
   function automatic logic [31:0] cnt_word(input logic [7:0] hi, input logic [7:0] lo,
                                            input logic odd, input logic [4:0] sel);
      return {9'd0, sel, odd, 1'b0, hi, lo};
   endfunction

   localparam logic [31:0] ModeWord  = 32'd1;
   localparam logic [31:0] StartWord = 32'd0;
   localparam logic [31:0] MWord     = cnt_word(8'd63, 8'd62, 1'b0, 5'd0);
   localparam logic [31:0] NWord     = cnt_word(8'd3, 8'd2, 1'b0, 5'd0);
   localparam logic [31:0] KWord     = 32'd214748365;

   // Index 0 is the power-up configuration: 250, 125, 50, 25 MHz.
   localparam logic [3:0][31:0] C0Table = {
      cnt_word(8'd25, 8'd25, 1'b0, 5'd0),
      cnt_word(8'd13, 8'd12, 1'b1, 5'd0),
      cnt_word(8'd5,  8'd5,  1'b0, 5'd0),
      cnt_word(8'd3,  8'd2,  1'b1, 5'd0)
   };

endpackage

// File: rtl/lock_filter.sv
// Counts consecutive high cycles of a lock input, saturating at Stable; the stable flag
// drops combinationally in the same cycle the lock input goes low.
module lock_filter #(
   parameter int unsigned Stable = 16
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic locked_i,
   output logic stable_o
);

   localparam int unsigned CntW = $clog2(Stable + 1);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || !locked_i) begin
         cnt_d = '0;
      end else if (cnt_q != CntW'(Stable)) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign stable_o = locked_i && !clr_i && (cnt_q == CntW'(Stable));

endmodule

// File: rtl/pll_reconfig_seq.sv
// Sequences a PLL output-frequency change through the Avalon-MM reconfig core: program
// M/N/K/C0, start, poll for completion, then wait for a stable lock.
module pll_reconfig_seq
   import pll_reconfig_pkg::*;
#(
   parameter int unsigned POLL_TIMEOUT = 4096,
   parameter int unsigned LOCK_STABLE  = 16,
   parameter int unsigned LOCK_TIMEOUT = 65535
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   input  logic [1:0]  req_profile,
   output logic        req_ready,
   output logic        done_pulse,
   output logic        err,
   output logic        busy,
   output logic [1:0]  cur_profile,
   output logic        lock_ok,
   output logic [5:0]  avm_address,
   output logic        avm_write,
   output logic        avm_read,
   output logic [31:0] avm_writedata,
   input  logic [31:0] avm_readdata,
   input  logic        avm_waitrequest,
   input  logic        pll_locked
);

   localparam int unsigned PollW = $clog2(POLL_TIMEOUT + 1);
   localparam int unsigned LkW   = $clog2(LOCK_TIMEOUT + 1);

   state_e           state_q;
   logic [1:0]       tgt_q, cur_q;
   logic             err_q, done_q, wr_q, rd_q;
   logic [5:0]       addr_q;
   logic [31:0]      data_q;
   logic [PollW-1:0] poll_cnt_q;
   logic [LkW-1:0]   lk_cnt_q;
   logic             xfer_done, wl_stable;
   logic             unused_rd;

   assign xfer_done = (wr_q || rd_q) && !avm_waitrequest;
   assign unused_rd = ^avm_readdata[31:1];

   lock_filter #(
      .Stable (LOCK_STABLE)
   ) u_lock_ok (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .clr_i    (1'b0),
      .locked_i (pll_locked),
      .stable_o (lock_ok)
   );

   // Held cleared outside WAIT_LOCK so every wait starts counting from zero.
   lock_filter #(
      .Stable (LOCK_STABLE)
   ) u_wait_lock (
      .clk_i    (clk),
      .rst_ni   (reset_n),
      .clr_i    (state_q != StWaitLock),
      .locked_i (pll_locked),
      .stable_o (wl_stable)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         tgt_q      <= '0;
         cur_q      <= '0;
         err_q      <= 1'b0;
         done_q     <= 1'b0;
         wr_q       <= 1'b0;
         rd_q       <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         poll_cnt_q <= '0;
         lk_cnt_q   <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (req_valid) begin
                  tgt_q <= req_profile;
                  err_q <= 1'b0;
                  if ((req_profile == cur_q) && !err_q) begin
                     state_q <= StDone;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= StWrMode;
                     wr_q    <= 1'b1;
                     addr_q  <= AddrMode;
                     data_q  <= ModeWord;
                  end
               end
            end
            StWrMode: begin
               if (xfer_done) begin
                  state_q <= StWrM;
                  addr_q  <= AddrM;
                  data_q  <= MWord;
               end
            end
            StWrM: begin
               if (xfer_done) begin
                  state_q <= StWrN;
                  addr_q  <= AddrN;
                  data_q  <= NWord;
               end
            end
            StWrN: begin
               if (xfer_done) begin
                  state_q <= StWrK;
                  addr_q  <= AddrK;
                  data_q  <= KWord;
               end
            end
            StWrK: begin
               if (xfer_done) begin
                  state_q <= StWrC0;
                  addr_q  <= AddrC0;
                  data_q  <= C0Table[tgt_q];
               end
            end
            StWrC0: begin
               if (xfer_done) begin
                  state_q <= StWrStart;
                  addr_q  <= AddrStart;
                  data_q  <= StartWord;
               end
            end
            StWrStart: begin
               if (xfer_done) begin
                  state_q    <= StPoll;
                  wr_q       <= 1'b0;
                  rd_q       <= 1'b1;
                  addr_q     <= AddrStatus;
                  data_q     <= '0;
                  poll_cnt_q <= '0;
               end
            end
            StPoll: begin
               // poll_cnt_q holds the reads already completed before this one.
               if (xfer_done) begin
                  if (avm_readdata[0]) begin
                     state_q  <= StWaitLock;
                     rd_q     <= 1'b0;
                     lk_cnt_q <= '0;
                  end else if (poll_cnt_q >= PollW'(POLL_TIMEOUT)) begin
                     state_q <= StErr;
                     rd_q    <= 1'b0;
                     done_q  <= 1'b1;
                     err_q   <= 1'b1;
                  end else begin
                     poll_cnt_q <= poll_cnt_q + PollW'(1);
                  end
               end
            end
            StWaitLock: begin
               if (wl_stable) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                  cur_q   <= tgt_q;
               end else if (lk_cnt_q >= LkW'(LOCK_TIMEOUT - 1)) begin
                  state_q <= StErr;
                  done_q  <= 1'b1;
                  err_q   <= 1'b1;
               end else begin
                  lk_cnt_q <= lk_cnt_q + LkW'(1);
               end
            end
            StDone, StErr: state_q <= StIdle;
            default:       state_q <= StIdle;
         endcase
      end
   end

   assign req_ready     = (state_q == StIdle);
   assign busy          = (state_q != StIdle);
   assign done_pulse    = done_q;
   assign err           = err_q;
   assign cur_profile   = cur_q;
   assign avm_address   = addr_q;
   assign avm_write     = wr_q;
   assign avm_read      = rd_q;
   assign avm_writedata = data_q;

endmodule

// File: doc/pll_reconfig_seq.md
PLL_RECONFIG_SEQ -- requirements
Module: pll_reconfig_seq

Interface
REQ-001 Parameter POLL_TIMEOUT, default 4096: maximum number of status reads before the block aborts.
REQ-002 Parameter LOCK_STABLE, default 16: number of consecutive high cycles of pll_locked that counts as lock.
REQ-003 Parameter LOCK_TIMEOUT, default 65535: maximum number of WAIT_LOCK cycles before the block aborts.
REQ-004 clk  in  1  single clock, shared by the reconfig Avalon slave.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  1  frequency-change request.
REQ-007 req_profile  in  2  target profile index (0..3).
REQ-008 req_ready  out  1  high only in IDLE.
REQ-009 done_pulse  out  1  one-cycle completion strobe, asserted on success and on error.
REQ-010 err  out  1  sticky failure flag.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 cur_profile  out  2  profile currently programmed into the PLL.
REQ-013 lock_ok  out  1  pll_locked has been high for at least LOCK_STABLE consecutive cycles.
REQ-014 avm_address  out  6; avm_write  out  1; avm_read  out  1; avm_writedata  out  32: Avalon-MM master outputs to the PLL reconfig core.
REQ-015 avm_readdata  in  32; avm_waitrequest  in  1: Avalon-MM master inputs.
REQ-016 pll_locked  in  1  PLL lock indication.

Function
REQ-017 A request SHALL be accepted on the cycle where req_valid and req_ready are both high; requests presented while busy is high SHALL be ignored and not queued.
REQ-018 An accepted request with req_profile equal to cur_profile and err low SHALL produce done_pulse on the next cycle with no Avalon traffic.
REQ-019 Otherwise the FSM SHALL step through IDLE, WR_MODE, WR_M, WR_N, WR_K, WR_C0, WR_START, POLL, WAIT_LOCK, then DONE or ERR, and return to IDLE.
REQ-020 The write sequence SHALL be: address 0 with data 1 (polling mode), address 4 with M, address 3 with N, address 7 with K, address 5 with C0, address 2 with data 0 (start).
REQ-021 Counter data format: bits [15:8] hi, [7:0] lo, bit 16 bypass, bit 17 odd-duty; for C0, bits [22:18] select counter 0; K is the full 32-bit value.
REQ-022 avm_address, avm_writedata and avm_write (or avm_read) SHALL be held stable while avm_waitrequest is high; the transfer completes in the first cycle with waitrequest low, and the FSM advances on the next cycle.
REQ-023 POLL SHALL issue reads to address 1; a completed read with readdata bit 0 = 1 SHALL enter WAIT_LOCK, and otherwise another read SHALL be issued.
REQ-024 If the number of reads exceeds POLL_TIMEOUT, the FSM SHALL enter ERR.
REQ-025 WAIT_LOCK SHALL count consecutive high cycles of pll_locked; a low cycle SHALL clear the count.
REQ-026 Reaching LOCK_STABLE SHALL enter DONE; reaching LOCK_TIMEOUT total cycles SHALL enter ERR; if both occur in the same cycle, DONE SHALL win.
REQ-027 In DONE, the block SHALL assert done_pulse for one cycle, load cur_profile with the new index and clear err.
REQ-028 In ERR, the block SHALL assert done_pulse for one cycle, set err and leave cur_profile unchanged.
REQ-029 err SHALL stay set until the next request is accepted.
REQ-030 lock_ok SHALL be computed continuously from its own counter, saturating at LOCK_STABLE and cleared in the same cycle pll_locked goes low.
REQ-031 avm_write and avm_read SHALL never be asserted together.

Reset
REQ-032 While reset_n is low: FSM in IDLE, cur_profile = 0, err, busy, done_pulse, avm_write, avm_read and lock_ok = 0, and all counters cleared.
REQ-033 Reset asserted mid-sequence SHALL drop any Avalon strobe immediately (asynchronous) and abandon the transaction.
REQ-034 Profile 0 SHALL match the PLL power-up configuration.

Structure
REQ-035 Package pll_reconfig_pkg SHALL hold the state enum, the register address constants, and the profile table.
REQ-036 All profiles SHALL use VCO 1250 MHz with M hi/lo 63/62, N 3/2, K 214748365; C0 per profile: 0 = 3/2 odd (250 MHz), 1 = 5/5 (125 MHz), 2 = 13/12 odd (50 MHz), 3 = 25/25 (25 MHz).
REQ-037 The consecutive-lock counter SHALL be the sub-module lock_filter, instanced twice: once for lock_ok and once for WAIT_LOCK.

Verification
REQ-038 Reset, then request profile 1 with waitrequest held low and status returning done on the 3rd read, and locked held high -> 6 writes in order, 3 reads, done_pulse, cur_profile = 1, err = 0.
REQ-039 Request profile 2 with waitrequest high for 5 cycles on every transfer -> address and data held stable, sequence completes correctly.
REQ-040 Status read never returns done, with POLL_TIMEOUT = 8 -> ERR after 9 reads, err = 1, done_pulse, cur_profile unchanged.
REQ-041 pll_locked toggles every 10 cycles with LOCK_STABLE = 16 -> ERR at LOCK_TIMEOUT; a follow-up request with stable lock -> success and err cleared.
REQ-042 Request the current profile -> done_pulse one cycle later with no avm_write; req_valid held high during busy -> no second acceptance.
REQ-043 reset_n pulsed low during WR_K -> avm_write = 0 immediately, FSM in IDLE, cur_profile = 0.
